// File: rtl/sd_fifo_sequencer_pkg.sv
// Shared definitions for the SD-side FIFO sequencer: default sizes, FSM state
// encoding and a counter-width helper.
package sd_fifo_sequencer_pkg;

  localparam int SD_DATA_W          = 32;
  localparam int SD_WORDS_PER_BLOCK = 128;  // 512-byte block of 32-bit words
  localparam int SD_BLK_CNT_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TX_FETCH = 3'd1,
    ST_TX_LOAD  = 3'd2,
    ST_TX_SEND  = 3'd3,
    ST_RX_RECV  = 3'd4,
    ST_FINISH   = 3'd5
  } seq_state_e;

  // Width of a counter that spans 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sd_fifo_sequencer_block_counter.sv
// Word-within-block and block counters for SD data transfers. Flags the last
// word of a block and the last block of the requested transfer.
module sd_block_counter
  import sd_fifo_sequencer_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = SD_WORDS_PER_BLOCK,
  parameter int BLK_CNT_W       = SD_BLK_CNT_W
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 clear_i,
  input  logic                 inc_i,
  input  logic [BLK_CNT_W-1:0] target_i,
  output logic                 last_word_o,
  output logic                 last_block_o
);

  localparam int WCNT_W = cnt_width(WORDS_PER_BLOCK);

  logic [WCNT_W-1:0]    word_q, word_d;
  logic [BLK_CNT_W-1:0] blk_q, blk_d;

  assign last_word_o  = (word_q == WCNT_W'(WORDS_PER_BLOCK - 1));
  assign last_block_o = (blk_q == target_i - BLK_CNT_W'(1));

  // NOTE: combinational next-state logic uses blocking assignments and gives
  // every output a default first, so no latch can be inferred.
  always_comb begin
    word_d = word_q;
    blk_d  = blk_q;
    if (clear_i) begin
      word_d = '0;
      blk_d  = '0;
    end else if (inc_i) begin
      if (last_word_o) begin
        word_d = '0;
        blk_d  = blk_q + BLK_CNT_W'(1);
      end else begin
        word_d = word_q + WCNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      word_q <= '0;
      blk_q  <= '0;
    end else begin
      word_q <= word_d;
      blk_q  <= blk_d;
    end
  end

endmodule

// File: rtl/sd_fifo_sequencer.sv
// SD-clock-domain sequencer moving whole blocks between the TX/RX FIFOs and the
// SD data PHY word interface; reports busy, done and sticky overrun error.
module sd_fifo_sequencer
  import sd_fifo_sequencer_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = SD_WORDS_PER_BLOCK,
  parameter int BLK_CNT_W       = SD_BLK_CNT_W,
  parameter int DATA_W          = SD_DATA_W
) (
  input  logic                 sd_clock,
  input  logic                 reset,
  input  logic                 start_tx,
  input  logic                 start_rx,
  input  logic [BLK_CNT_W-1:0] num_blocks,
  input  logic [DATA_W-1:0]    tx_fifo_q,
  input  logic                 tx_fifo_empty,
  output logic                 tx_fifo_rd_en,
  output logic [DATA_W-1:0]    phy_tx_data,
  output logic                 phy_tx_valid,
  input  logic                 phy_tx_ready,
  input  logic [DATA_W-1:0]    phy_rx_data,
  input  logic                 phy_rx_valid,
  output logic [DATA_W-1:0]    rx_fifo_data,
  output logic                 rx_fifo_wr_en,
  input  logic                 rx_fifo_full,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  seq_state_e           state_q;
  logic [BLK_CNT_W-1:0] num_blocks_q;
  logic [DATA_W-1:0]    phy_tx_data_q;
  logic                 phy_tx_valid_q;
  logic [DATA_W-1:0]    rx_fifo_data_q;
  logic                 rx_fifo_wr_en_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 error_q;

  logic start_accept;
  logic tx_handshake;
  logic rx_take;
  logic last_word;
  logic last_block;
  logic last_xfer;

  assign start_accept = (state_q == ST_IDLE) && (start_tx || start_rx);
  assign tx_handshake = (state_q == ST_TX_SEND) && phy_tx_valid_q && phy_tx_ready;
  assign rx_take      = (state_q == ST_RX_RECV) && phy_rx_valid && !rx_fifo_full;
  assign last_xfer    = last_word && last_block;

  // The FIFO returns data one cycle after the enable, so the enable is decoded
  // straight from the FETCH state; that lets LOAD capture valid read data.
  assign tx_fifo_rd_en = (state_q == ST_TX_FETCH) && !tx_fifo_empty;

  sd_block_counter #(
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
    .BLK_CNT_W       (BLK_CNT_W)
  ) u_block_counter (
    .clk_i        (sd_clock),
    .reset_i      (reset),
    .clear_i      (start_accept),
    .inc_i        (tx_handshake || rx_take),
    .target_i     (num_blocks_q),
    .last_word_o  (last_word),
    .last_block_o (last_block)
  );

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      // NOTE: data registers are reset too, so every output reads 0 after an
      // aborted transfer rather than showing a stale word.
      state_q         <= ST_IDLE;
      num_blocks_q    <= '0;
      phy_tx_data_q   <= '0;
      phy_tx_valid_q  <= 1'b0;
      rx_fifo_data_q  <= '0;
      rx_fifo_wr_en_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      done_q          <= 1'b0;
      rx_fifo_wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_tx || start_rx) begin
            num_blocks_q <= num_blocks;
            error_q      <= 1'b0;
            busy_q       <= 1'b1;
            if (num_blocks == '0)
              state_q <= ST_FINISH;
            else if (start_tx)
              state_q <= ST_TX_FETCH;
            else
              state_q <= ST_RX_RECV;
          end
        end
        ST_TX_FETCH: begin
          if (!tx_fifo_empty)
            state_q <= ST_TX_LOAD;
        end
        ST_TX_LOAD: begin
          phy_tx_data_q  <= tx_fifo_q;
          phy_tx_valid_q <= 1'b1;
          state_q        <= ST_TX_SEND;
        end
        ST_TX_SEND: begin
          if (tx_handshake) begin
            phy_tx_valid_q <= 1'b0;
            state_q        <= last_xfer ? ST_FINISH : ST_TX_FETCH;
          end
        end
        ST_RX_RECV: begin
          if (phy_rx_valid) begin
            if (!rx_fifo_full) begin
              rx_fifo_data_q  <= phy_rx_data;
              rx_fifo_wr_en_q <= 1'b1;
              if (last_xfer)
                state_q <= ST_FINISH;
            end else begin
              // Overrun: the word is lost, so the whole transfer is aborted.
              error_q <= 1'b1;
              state_q <= ST_FINISH;
            end
          end
        end
        ST_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign phy_tx_data   = phy_tx_data_q;
  assign phy_tx_valid  = phy_tx_valid_q;
  assign rx_fifo_data  = rx_fifo_data_q;
  assign rx_fifo_wr_en = rx_fifo_wr_en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_sd_fifo_sequencer.sv
// Self-checking bench for sd_fifo_sequencer with a behavioural TX FIFO and
// scoreboard queues for PHY TX words and RX FIFO writes.
module tb_sd_fifo_sequencer;

  localparam int WPB = 4;
  localparam int BW  = 16;
  localparam int DW  = 32;

  logic          sd_clock = 1'b0;
  logic          reset;
  logic          start_tx, start_rx;
  logic [BW-1:0] num_blocks;
  logic [DW-1:0] tx_fifo_q;
  logic          tx_fifo_empty;
  logic          tx_fifo_rd_en;
  logic [DW-1:0] phy_tx_data;
  logic          phy_tx_valid;
  logic          phy_tx_ready;
  logic [DW-1:0] phy_rx_data;
  logic          phy_rx_valid;
  logic [DW-1:0] rx_fifo_data;
  logic          rx_fifo_wr_en;
  logic          rx_fifo_full;
  logic          busy, done, error;

  always #5 sd_clock = ~sd_clock;

  sd_fifo_sequencer #(
    .WORDS_PER_BLOCK (WPB),
    .BLK_CNT_W       (BW),
    .DATA_W          (DW)
  ) dut (
    .sd_clock      (sd_clock),
    .reset         (reset),
    .start_tx      (start_tx),
    .start_rx      (start_rx),
    .num_blocks    (num_blocks),
    .tx_fifo_q     (tx_fifo_q),
    .tx_fifo_empty (tx_fifo_empty),
    .tx_fifo_rd_en (tx_fifo_rd_en),
    .phy_tx_data   (phy_tx_data),
    .phy_tx_valid  (phy_tx_valid),
    .phy_tx_ready  (phy_tx_ready),
    .phy_rx_data   (phy_rx_data),
    .phy_rx_valid  (phy_rx_valid),
    .rx_fifo_data  (rx_fifo_data),
    .rx_fifo_wr_en (rx_fifo_wr_en),
    .rx_fifo_full  (rx_fifo_full),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural TX FIFO: read data appears one cycle after rd_en.
  logic [DW-1:0] tx_mem[$];
  logic [DW-1:0] tx_exp[$];
  logic [DW-1:0] rx_exp[$];
  int tx_pushed = 0;
  int tx_popped = 0;

  assign tx_fifo_empty = (tx_pushed == tx_popped);

  always @(posedge sd_clock) begin
    if (tx_fifo_rd_en && tx_mem.size() > 0) begin
      tx_fifo_q <= tx_mem.pop_front();
      tx_popped <= tx_popped + 1;
    end
  end

  // Monitor: samples on the falling edge, away from the active edge.
  int cyc = 0;
  int rd_cnt = 0, hs_cnt = 0, wr_cnt = 0, done_cnt = 0, valid_cnt = 0;
  int stall_cnt = 0, overlap_cnt = 0;
  int last_wr_cyc = 0, last_done_cyc = 0;
  bit prev_stall = 1'b0, prev_rx_ok = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge sd_clock) begin
    cyc++;
    if (reset) begin
      prev_stall = 1'b0;
      prev_rx_ok = 1'b0;
    end else begin
      if (tx_fifo_rd_en) rd_cnt++;
      if (phy_tx_valid) valid_cnt++;
      if (tx_fifo_rd_en && rx_fifo_wr_en) overlap_cnt++;
      if (prev_stall) begin
        check("tx_hold_valid", 32'(phy_tx_valid), 1);
        check("tx_hold_data", phy_tx_data, prev_data);
      end
      prev_stall = phy_tx_valid && !phy_tx_ready;
      prev_data  = phy_tx_data;
      if (phy_tx_valid && !phy_tx_ready) stall_cnt++;
      if (phy_tx_valid && phy_tx_ready) begin
        hs_cnt++;
        check("tx_sb_avail", 32'(tx_exp.size() != 0), 1);
        if (tx_exp.size() != 0) check("tx_word", phy_tx_data, tx_exp.pop_front());
      end
      if (rx_fifo_wr_en || prev_rx_ok)
        check("rx_wr_timing", 32'(rx_fifo_wr_en), 32'(prev_rx_ok));
      if (rx_fifo_wr_en) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        check("rx_sb_avail", 32'(rx_exp.size() != 0), 1);
        if (rx_exp.size() != 0) check("rx_word", rx_fifo_data, rx_exp.pop_front());
      end
      prev_rx_ok = phy_rx_valid && !rx_fifo_full;
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
        check("busy_low_on_done", 32'(busy), 0);
      end
    end
  end

  task automatic load_tx(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      tx_mem.push_back(first + DW'(i));
      tx_exp.push_back(first + DW'(i));
      tx_pushed++;
    end
  endtask

  task automatic flush_tx();
    tx_mem.delete();
    tx_exp.delete();
    tx_pushed = tx_popped;
  endtask

  task automatic pulse_start(input bit tx, input bit rx, input int nblk);
    @(posedge sd_clock); #1;
    start_tx   = tx;
    start_rx   = rx;
    num_blocks = BW'(nblk);
    @(posedge sd_clock); #1;
    start_tx = 1'b0;
    start_rx = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge sd_clock); #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 1);
    repeat (2) @(negedge sd_clock);
  endtask

  // Runs a TX transfer; optionally stalls the PHY for stall_len cycles on stall_word.
  task automatic run_tx(input string tag, input bit also_rx, input int nblk,
                        input logic [DW-1:0] stall_word, input int stall_len);
    int left = stall_len;
    bit ok = 1'b0;
    phy_tx_ready = 1'b1;
    pulse_start(1'b1, also_rx, nblk);
    check({tag, "_busy"}, 32'(busy), 1);
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (phy_tx_valid && phy_tx_data == stall_word && left > 0) begin
        phy_tx_ready = 1'b0;
        left--;
      end else begin
        phy_tx_ready = 1'b1;
      end
      @(posedge sd_clock); #1;
    end
    phy_tx_ready = 1'b1;
    check({tag, "_done"}, 32'(ok), 1);
    repeat (2) @(negedge sd_clock);
  endtask

  task automatic strobe_rx(input logic [DW-1:0] d, input bit full);
    @(posedge sd_clock); #1;
    phy_rx_valid = 1'b1;
    phy_rx_data  = d;
    rx_fifo_full = full;
    if (!full) rx_exp.push_back(d);
    @(posedge sd_clock); #1;
    phy_rx_valid = 1'b0;
    rx_fifo_full = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, hs0, wr0, dn0, vl0, st0;
    reset = 1'b1; start_tx = 1'b0; start_rx = 1'b0; num_blocks = '0;
    tx_fifo_q = '0; phy_tx_ready = 1'b1; phy_rx_data = '0; phy_rx_valid = 1'b0;
    rx_fifo_full = 1'b0;
    repeat (3) @(posedge sd_clock); #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_rd_en", 32'(tx_fifo_rd_en), 0);
    check("rst_tx_valid", 32'(phy_tx_valid), 0);
    check("rst_tx_data", phy_tx_data, 0);
    check("rst_wr_en", 32'(rx_fifo_wr_en), 0);
    reset = 1'b0;

    // TX: two blocks of words 1..8, PHY always ready.
    load_tx(32'h1, 8);
    rd0 = rd_cnt; hs0 = hs_cnt; dn0 = done_cnt;
    run_tx("tx2blk", 1'b0, 2, '0, 0);
    check("tx2blk_hs", 32'(hs_cnt - hs0), 8);
    check("tx2blk_rd", 32'(rd_cnt - rd0), 8);
    check("tx2blk_done_cnt", 32'(done_cnt - dn0), 1);
    check("tx2blk_error", 32'(error), 0);
    check("tx2blk_sb_empty", 32'(tx_exp.size()), 0);

    // TX with the PHY stalling for 5 cycles on word 3.
    load_tx(32'h1, 8);
    rd0 = rd_cnt; hs0 = hs_cnt; dn0 = done_cnt; st0 = stall_cnt;
    run_tx("txstall", 1'b0, 2, 32'h3, 5);
    check("txstall_cycles", 32'(stall_cnt - st0), 5);
    check("txstall_hs", 32'(hs_cnt - hs0), 8);
    check("txstall_rd", 32'(rd_cnt - rd0), 8);
    check("txstall_done_cnt", 32'(done_cnt - dn0), 1);

    // RX: one block of 0xA0..0xA3.
    wr0 = wr_cnt; dn0 = done_cnt;
    pulse_start(1'b0, 1'b1, 1);
    for (int i = 0; i < 4; i++) strobe_rx(32'hA0 + 32'(i), 1'b0);
    wait_done("rx1blk_done", 20);
    check("rx1blk_wr", 32'(wr_cnt - wr0), 4);
    check("rx1blk_done_cnt", 32'(done_cnt - dn0), 1);
    check("rx1blk_done_lat", 32'(last_done_cyc - last_wr_cyc), 1);
    check("rx1blk_error", 32'(error), 0);

    // RX overrun on the second strobe, then a fresh start clears error.
    wr0 = wr_cnt;
    pulse_start(1'b0, 1'b1, 1);
    strobe_rx(32'hA0, 1'b0);
    strobe_rx(32'hA1, 1'b1);
    wait_done("rxovr_done", 20);
    check("rxovr_wr", 32'(wr_cnt - wr0), 1);
    check("rxovr_error", 32'(error), 1);
    pulse_start(1'b0, 1'b1, 1);
    check("rxovr_error_clr", 32'(error), 0);
    wr0 = wr_cnt;
    for (int i = 0; i < 4; i++) strobe_rx(32'hB0 + 32'(i), 1'b0);
    wait_done("rxrerun_done", 20);
    check("rxrerun_wr", 32'(wr_cnt - wr0), 4);
    check("rxrerun_error", 32'(error), 0);
    check("rx_sb_empty", 32'(rx_exp.size()), 0);

    // Zero-block TX: done quickly with no FIFO or PHY activity.
    rd0 = rd_cnt; vl0 = valid_cnt; dn0 = done_cnt;
    pulse_start(1'b1, 1'b0, 0);
    wait_done("tx0_done", 2);
    check("tx0_rd", 32'(rd_cnt - rd0), 0);
    check("tx0_valid", 32'(valid_cnt - vl0), 0);
    check("tx0_done_cnt", 32'(done_cnt - dn0), 1);

    // Simultaneous start_tx/start_rx: TX path only.
    load_tx(32'h51, 4);
    hs0 = hs_cnt; wr0 = wr_cnt; rd0 = rd_cnt;
    run_tx("both", 1'b1, 1, '0, 0);
    check("both_hs", 32'(hs_cnt - hs0), 4);
    check("both_rd", 32'(rd_cnt - rd0), 4);
    check("both_wr", 32'(wr_cnt - wr0), 0);

    // Reset while word 2 sits in TX_SEND.
    load_tx(32'h1, 8);
    dn0 = done_cnt;
    pulse_start(1'b1, 1'b0, 2);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(posedge sd_clock); #1;
        if (phy_tx_valid && phy_tx_data == 32'h2) begin
          seen = 1'b1;
          break;
        end
      end
      check("rstmid_reach_word2", 32'(seen), 1);
    end
    reset = 1'b1;
    @(posedge sd_clock); #1;
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_valid", 32'(phy_tx_valid), 0);
    check("rstmid_data", phy_tx_data, 0);
    check("rstmid_rd_en", 32'(tx_fifo_rd_en), 0);
    check("rstmid_done", 32'(done), 0);
    reset = 1'b0;
    rd0 = rd_cnt;
    repeat (5) @(negedge sd_clock);
    check("rstmid_no_done", 32'(done_cnt - dn0), 0);
    check("rstmid_no_rd", 32'(rd_cnt - rd0), 0);
    flush_tx();
    load_tx(32'h1, 8);
    hs0 = hs_cnt; rd0 = rd_cnt; dn0 = done_cnt;
    run_tx("rerun", 1'b0, 2, '0, 0);
    check("rerun_hs", 32'(hs_cnt - hs0), 8);
    check("rerun_rd", 32'(rd_cnt - rd0), 8);
    check("rerun_done_cnt", 32'(done_cnt - dn0), 1);
    check("rerun_sb_empty", 32'(tx_exp.size()), 0);

    check("rd_wr_overlap", 32'(overlap_cnt), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
